leaf_stream_packetizer: RTL

- Transmit-side endpoint of the BFT leaf stream protocol.
- Accepts 32-bit words from a user/DMA source over valid/ready and wraps each word into a BFT packet addressed to a remote leaf input port, with a rolling BRAM write address.
- Meters traffic against the receiver's buffer using credits returned in free-space update packets, and re-drives any packet the network bounces with resend.
- Sits between a host-side user stream and the BFT switch port of the sending leaf.

---
 rtl/leaf_stream_packetizer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/leaf_stream_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : leaf_stream_packetizer
// Brief    : Transmit endpoint of the BFT leaf stream protocol. Wraps user
//            words into BFT packets with a rolling receiver buffer address,
//            meters them against returned credits and re-drives bounced
//            packets.
// Revision : 1.0 - initial release
// ============================================================================
module leaf_stream_packetizer #(
    parameter int PACKET_BITS        = 49,
    parameter int PAYLOAD_BITS       = 32,
    parameter int NUM_LEAF_BITS      = 3,
    parameter int NUM_PORT_BITS      = 4,
    parameter int NUM_ADDR_BITS      = 7,
    parameter int NUM_BRAM_ADDR_BITS = 7,
    parameter int CREDIT_PORT        = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_load,
    input  logic [NUM_LEAF_BITS-1:0]      cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0]      cfg_dst_port,
    input  logic [NUM_LEAF_BITS-1:0]      cfg_src_leaf,
    input  logic [NUM_PORT_BITS-1:0]      cfg_src_port,
    input  logic [PAYLOAD_BITS-1:0]       in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [PACKET_BITS-1:0]        dout_leaf_interface2bft,
    input  logic                          resend,
    input  logic [PACKET_BITS-1:0]        din_leaf_bft2interface,
    output logic                          busy,
    output logic [NUM_BRAM_ADDR_BITS:0]   credits
);

    // Zero bits between the address field and the payload.
    localparam int GAP_BITS = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS
                              - NUM_ADDR_BITS - PAYLOAD_BITS;
    localparam int CRED_W   = NUM_BRAM_ADDR_BITS + 1;

    localparam logic [CRED_W-1:0] c_credit_max = {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_config = 2'd1;
    localparam logic [1:0] c_st_stream = 2'd2;

    logic [1:0]                    state_q,    state_d;
    logic [PACKET_BITS-1:0]        dout_q,     dout_d;
    logic [NUM_BRAM_ADDR_BITS-1:0] addr_q,     addr_d;
    logic [CRED_W-1:0]             credits_q,  credits_d;
    logic [NUM_LEAF_BITS-1:0]      dst_leaf_q, dst_leaf_d;
    logic [NUM_PORT_BITS-1:0]      dst_port_q, dst_port_d;

    logic                     w_hold;
    logic                     w_xfer;
    logic                     w_credit_hit;
    logic [NUM_PORT_BITS-1:0] w_din_port;
    logic [CRED_W-1:0]        w_credit_add;
    logic [CRED_W:0]          w_credit_sum;
    logic                     w_din_unused;

    function automatic logic [PACKET_BITS-1:0] make_pkt(
        input logic [NUM_LEAF_BITS-1:0] leaf,
        input logic [NUM_PORT_BITS-1:0] port,
        input logic [NUM_ADDR_BITS-1:0] addr,
        input logic [PAYLOAD_BITS-1:0]  payload
    );
        return {1'b1, leaf, port, addr, {GAP_BITS{1'b0}}, payload};
    endfunction

    // Only valid, port and the low credit bits of incoming packets matter.
    assign w_din_unused = ^din_leaf_bft2interface;

    assign w_din_port   = din_leaf_bft2interface[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS];
    assign w_credit_hit = din_leaf_bft2interface[PACKET_BITS-1]
                          && (w_din_port == NUM_PORT_BITS'(CREDIT_PORT));
    assign w_credit_add = w_credit_hit ? din_leaf_bft2interface[NUM_BRAM_ADDR_BITS:0] : '0;

    // A bounced valid packet must be held, so no new word may enter that cycle.
    assign w_hold   = dout_q[PACKET_BITS-1] && resend;
    assign in_ready = (state_q == c_st_stream) && (credits_q != '0) && !w_hold;
    assign w_xfer   = in_valid && in_ready;

    // A transfer implies credits_q >= 1, so the subtraction never underflows.
    assign w_credit_sum = (CRED_W+1)'(credits_q) + (CRED_W+1)'(w_credit_add)
                          - (CRED_W+1)'(w_xfer);

    assign dout_leaf_interface2bft = dout_q;
    assign busy                    = (state_q != c_st_idle);
    assign credits                 = credits_q;

    // Next-state, output packet, address counter and credit computation.
    always_comb begin
        state_d    = state_q;
        dout_d     = '0;
        addr_d     = addr_q;
        dst_leaf_d = dst_leaf_q;
        dst_port_d = dst_port_q;
        credits_d  = (w_credit_sum > (CRED_W+1)'(c_credit_max)) ? c_credit_max
                                                                 : w_credit_sum[CRED_W-1:0];
        case (state_q)
            c_st_idle: begin
                // Source ids only feed the config packet, captured straight into dout.
                if (cfg_load) begin
                    dst_leaf_d = cfg_dst_leaf;
                    dst_port_d = cfg_dst_port;
                    dout_d     = make_pkt(cfg_dst_leaf, '0, '0,
                                          PAYLOAD_BITS'({cfg_src_leaf, cfg_src_port}));
                    state_d    = c_st_config;
                end
            end
            c_st_config: begin
                if (w_hold) begin
                    dout_d = dout_q;
                end else begin
                    state_d = c_st_stream;
                end
            end
            c_st_stream: begin
                if (w_hold) begin
                    dout_d = dout_q;
                end else if (w_xfer) begin
                    dout_d = make_pkt(dst_leaf_q, dst_port_q,
                                      NUM_ADDR_BITS'(addr_q), in_data);
                    addr_d = addr_q + NUM_BRAM_ADDR_BITS'(1);
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= c_st_idle;
            dout_q     <= '0;
            addr_q     <= '0;
            credits_q  <= c_credit_max;
            dst_leaf_q <= '0;
            dst_port_q <= '0;
        end else begin
            state_q    <= state_d;
            dout_q     <= dout_d;
            addr_q     <= addr_d;
            credits_q  <= credits_d;
            dst_leaf_q <= dst_leaf_d;
            dst_port_q <= dst_port_d;
        end
    end

endmodule
`default_nettype wire
